// File: rtl/run_detect_fsm.sv
// run_detect_fsm: per-channel run detector.
// Each of CHANNELS serial inputs is watched for RUN_LEN consecutive samples
// equal to pol_i. z_o[k] is a registered Moore flag that stays high while the
// qualifying run continues. en_i = 0 soft-clears every channel.
// Optional macro RUN_DET_CNT_EN adds per-channel saturating detection counters
// (ports clr_i, det_cnt_o).
//
// Handshake note: there is no valid/ready flow here; w_i is sampled on every
// rising clk edge while en_i = 1, and z_o/det_cnt_o are valid every cycle.
module run_detect_fsm #(
  parameter int CHANNELS = 4,
  parameter int RUN_LEN  = 2,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic                      pol_i,
  input  logic [CHANNELS-1:0]       w_i,
  output logic [CHANNELS-1:0]       z_o
`ifdef RUN_DET_CNT_EN
  ,
  input  logic                      clr_i,
  output logic [CHANNELS*CNT_W-1:0] det_cnt_o
`endif
);

  localparam int            CW      = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DET  = 2'd2
  } state_t;

  // state_q is the per-channel FSM state, kept as a named array for probing.
  state_t          state_q [CHANNELS];
  state_t          state_d [CHANNELS];
  logic [CW-1:0]   cnt_q   [CHANNELS];
  logic [CW-1:0]   cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] match;

  // A sample matches when it equals the polarity in force on this edge.
  assign match = pol_i ? w_i : ~w_i;

  // State and run-counter registers; reset discards any partial run.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (rst) begin
        state_q[k] <= S_IDLE;
        cnt_q[k]   <= '0;
      end else begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Next-state logic per channel; disable forces every channel back to IDLE.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      if (!en_i) begin
        state_d[k] = S_IDLE;
        cnt_d[k]   = '0;
      end else begin
        case (state_q[k])
          S_IDLE: begin
            if (match[k]) begin
              cnt_d[k]   = CNT_ONE;
              state_d[k] = (RUN_LEN == 1) ? S_DET : S_RUN;
            end
          end
          S_RUN: begin
            if (match[k]) begin
              cnt_d[k]   = cnt_q[k] + CNT_ONE;
              state_d[k] = ((cnt_q[k] + CNT_ONE) == RUN_MAX) ? S_DET : S_RUN;
            end else begin
              cnt_d[k]   = '0;
              state_d[k] = S_IDLE;
            end
          end
          S_DET: begin
            // Counter stays saturated at RUN_LEN while the run continues.
            if (!match[k]) begin
              cnt_d[k]   = '0;
              state_d[k] = S_IDLE;
            end
          end
          default: begin
            cnt_d[k]   = '0;
            state_d[k] = S_IDLE;
          end
        endcase
      end
    end
  end

  // Detect flag is a pure decode of the registered state.
  always_comb begin
    z_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      z_o[k] = (state_q[k] == S_DET);
    end
  end

`ifdef RUN_DET_CNT_EN
  localparam logic [CNT_W-1:0] DCNT_MAX = '1;
  localparam logic [CNT_W-1:0] DCNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] det_cnt_q [CHANNELS];

  // Count each entry into DET once; saturate, and let clr_i beat an increment.
  always_ff @(posedge clk) begin
    for (int k = 0; k < CHANNELS; k++) begin
      if (rst || clr_i) begin
        det_cnt_q[k] <= '0;
      end else if ((state_d[k] == S_DET) && (state_q[k] != S_DET) &&
                   (det_cnt_q[k] != DCNT_MAX)) begin
        det_cnt_q[k] <= det_cnt_q[k] + DCNT_ONE;
      end
    end
  end

  // Pack the per-channel counters, channel k at [k*CNT_W +: CNT_W].
  always_comb begin
    det_cnt_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      det_cnt_o[k*CNT_W +: CNT_W] = det_cnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_run_detect_fsm.sv
// tb_run_detect_fsm: three run_detect_fsm instances (RUN_LEN = 1, 2, 3) share
// one stimulus stream. A directed table, hand sequences for counters, and a
// randomized phase are each checked; every step is also compared against a
// run-length reference model.
module tb_run_detect_fsm;

  localparam int CH = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en_i;
  logic             pol_i;
  logic             clr_i;
  logic [CH-1:0]    w_i;
  logic [CH-1:0]    z1, z2, z3;
  logic [CH*CW-1:0] c1, c2, c3;

  int n_checks = 0;
  int n_errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  run_detect_fsm #(.CHANNELS(CH), .RUN_LEN(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .en_i(en_i), .pol_i(pol_i), .w_i(w_i), .z_o(z1)
`ifdef RUN_DET_CNT_EN
    , .clr_i(clr_i), .det_cnt_o(c1)
`endif
  );
  run_detect_fsm #(.CHANNELS(CH), .RUN_LEN(2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .rst(rst), .en_i(en_i), .pol_i(pol_i), .w_i(w_i), .z_o(z2)
`ifdef RUN_DET_CNT_EN
    , .clr_i(clr_i), .det_cnt_o(c2)
`endif
  );
  run_detect_fsm #(.CHANNELS(CH), .RUN_LEN(3), .CNT_W(CW)) u_dut3 (
    .clk(clk), .rst(rst), .en_i(en_i), .pol_i(pol_i), .w_i(w_i), .z_o(z3)
`ifdef RUN_DET_CNT_EN
    , .clr_i(clr_i), .det_cnt_o(c3)
`endif
  );

`ifndef RUN_DET_CNT_EN
  assign c1 = '0;
  assign c2 = '0;
  assign c3 = '0;
`endif

  // Reference model: length of the current matching run per channel, and
  // the number of runs that reached RUN_LEN (saturating at 2^CW-1).
  int len_m [3][CH];
  int cnt_m [3][CH];

  typedef struct {
    logic          r;
    logic          e;
    logic          p;
    logic [CH-1:0] w;
    int            sel;
    logic [CH-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CH-1:0] get_z(input int sel);
    case (sel)
      1:       return z1;
      2:       return z2;
      default: return z3;
    endcase
  endfunction

  function automatic logic [CH*CW-1:0] get_c(input int sel);
    case (sel)
      1:       return c1;
      2:       return c2;
      default: return c3;
    endcase
  endfunction

  task automatic model_update();
    int rl;
    for (int d = 0; d < 3; d++) begin
      rl = d + 1;
      for (int k = 0; k < CH; k++) begin
        if (rst) begin
          len_m[d][k] = 0;
          cnt_m[d][k] = 0;
        end else begin
          if (!en_i) begin
            len_m[d][k] = 0;
          end else if (w_i[k] == pol_i) begin
            if (len_m[d][k] < 1000) len_m[d][k]++;
            if (len_m[d][k] == rl && cnt_m[d][k] < (2**CW - 1)) cnt_m[d][k]++;
          end else begin
            len_m[d][k] = 0;
          end
          if (clr_i) cnt_m[d][k] = 0;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [CH-1:0]    ez;
    logic [CH*CW-1:0] ec;
    for (int d = 0; d < 3; d++) begin
      ez = '0;
      ec = '0;
      for (int k = 0; k < CH; k++) begin
        ez[k] = (len_m[d][k] >= d + 1);
        ec[k*CW +: CW] = CW'(cnt_m[d][k]);
      end
      check($sformatf("model_z_rl%0d", d + 1), 32'(get_z(d + 1)), 32'(ez));
`ifdef RUN_DET_CNT_EN
      check($sformatf("model_cnt_rl%0d", d + 1), 32'(get_c(d + 1)), 32'(ec));
`endif
    end
  endtask

  // driver task: one sample per rising edge, outputs checked 1 time unit later
  task automatic step(input logic r, input logic e, input logic p, input logic c,
                      input logic [CH-1:0] w);
    @(negedge clk);
    rst   = r;
    en_i  = e;
    pol_i = p;
    clr_i = c;
    w_i   = w;
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  function automatic void add(input logic r, input logic e, input logic p,
                              input logic [CH-1:0] w, input int sel,
                              input logic [CH-1:0] exp);
    vec_t v;
    v.r = r; v.e = e; v.p = p; v.w = w; v.sel = sel; v.exp = exp;
    tbl.push_back(v);
  endfunction

  initial begin
    rst   = 1'b1;
    en_i  = 1'b0;
    pol_i = 1'b1;
    clr_i = 1'b0;
    w_i   = '0;
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < CH; k++) begin
        len_m[d][k] = 0;
        cnt_m[d][k] = 0;
      end

    // RUN_LEN=2, ones: isolated 1, pair, triple.
    add(1, 1, 1, 4'b0000, 2, 4'b0000);
    add(0, 1, 1, 4'b1111, 2, 4'b0000);
    add(0, 1, 1, 4'b0000, 2, 4'b0000);
    add(0, 1, 1, 4'b1111, 2, 4'b0000);
    add(0, 1, 1, 4'b1111, 2, 4'b1111);
    add(0, 1, 1, 4'b0000, 2, 4'b0000);
    add(0, 1, 1, 4'b1111, 2, 4'b0000);
    add(0, 1, 1, 4'b1111, 2, 4'b1111);
    add(0, 1, 1, 4'b1111, 2, 4'b1111);
    add(0, 1, 1, 4'b0000, 2, 4'b0000);
    // RUN_LEN=1, zeros: channel 0 sees 1,0,0,1; others independent.
    add(1, 1, 0, 4'b0000, 1, 4'b0000);
    add(0, 1, 0, 4'b0101, 1, 4'b1010);
    add(0, 1, 0, 4'b1100, 1, 4'b0011);
    add(0, 1, 0, 4'b0110, 1, 4'b1001);
    add(0, 1, 0, 4'b1011, 1, 4'b0100);
    // RUN_LEN=3: reset mid-run, then enable drop while detecting.
    add(1, 1, 1, 4'b0000, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b0000);
    add(1, 1, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b1111);
    add(0, 1, 1, 4'b1111, 3, 4'b1111);
    add(0, 0, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b0000);
    add(0, 1, 1, 4'b1111, 3, 4'b1111);
    add(0, 1, 1, 4'b0000, 3, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].p, 1'b0, tbl[i].w);
      check($sformatf("tbl%0d", i), 32'(get_z(tbl[i].sel)), 32'(tbl[i].exp));
    end

`ifdef RUN_DET_CNT_EN
    // Five separate qualifying runs on RUN_LEN=2 with a 2-bit counter.
    begin
      logic [CW-1:0] ev;
      step(1, 1, 1, 0, 4'b0000);
      check("cnt_after_rst", 32'(c2), 32'd0);
      for (int r = 0; r < 5; r++) begin
        step(0, 1, 1, 0, 4'b1111);
        step(0, 1, 1, 0, 4'b1111);
        ev = (r < 3) ? CW'(r + 1) : CW'(3);
        check($sformatf("cnt_run%0d", r), 32'(c2), 32'({CH{ev}}));
        step(0, 1, 1, 0, 4'b0000);
      end
      // clr_i on the same edge as DET entry: counter 0, flag high.
      step(0, 1, 1, 0, 4'b1111);
      step(0, 1, 1, 1, 4'b1111);
      check("clr_vs_inc_cnt", 32'(c2), 32'd0);
      check("clr_vs_inc_z", 32'(z2), 32'hf);
    end
`endif

    // Randomized phase, checked against the model on every step.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) != 0),
           (($urandom_range(0, 19) == 0) ? ~pol_i : pol_i),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0) ? CH'($urandom) : {CH{pol_i}});
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
